// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code step tracker: state encoding and the
// 3-bit Gray sequence emitted by the upstream up/down counter.
package gray_pkg;

  localparam int unsigned CODE_W = 3;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    S_INIT  = ST_INIT,
    S_TRACK = ST_TRACK,
    S_FAULT = ST_FAULT
  } state_t;

  // Gray code for positions 0..7 (bit2=y1, bit1=y2, bit0=y3)
  localparam logic [CODE_W-1:0] G0 = 3'b000;
  localparam logic [CODE_W-1:0] G1 = 3'b001;
  localparam logic [CODE_W-1:0] G2 = 3'b011;
  localparam logic [CODE_W-1:0] G3 = 3'b010;
  localparam logic [CODE_W-1:0] G4 = 3'b110;
  localparam logic [CODE_W-1:0] G5 = 3'b111;
  localparam logic [CODE_W-1:0] G6 = 3'b101;
  localparam logic [CODE_W-1:0] G7 = 3'b100;

endpackage

// File: rtl/gray2bin.sv
// Combinational 3-bit Gray-to-binary decoder, reusable by display logic.
module gray2bin
  import gray_pkg::*;
(
  input  logic [CODE_W-1:0] gray,
  output logic [CODE_W-1:0] bin
);

  // Table form of bin[i] = XOR of gray[2:i]
  always_comb begin
    bin = '0;
    case (gray)
      G0:      bin = 3'd0;
      G1:      bin = 3'd1;
      G2:      bin = 3'd2;
      G3:      bin = 3'd3;
      G4:      bin = 3'd4;
      G5:      bin = 3'd5;
      G6:      bin = 3'd6;
      G7:      bin = 3'd7;
      default: bin = '0;
    endcase
  end

endmodule

// File: rtl/gray_step_tracker.sv
// Tracks a 3-bit Gray counter: decodes each sample, pulses on +/-1 steps,
// keeps position and revolution counts, and latches a fault on jumps.
module gray_step_tracker
  import gray_pkg::*;
#(
  parameter int unsigned POS_W = 8,
  parameter int unsigned REV_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] gray_in,
  input  logic              err_clr,
  output logic [CODE_W-1:0] bin_out,
  output logic              step_up,
  output logic              step_dn,
  output logic [POS_W-1:0]  position,
  output logic [REV_W-1:0]  rev,
  output logic              err,
  output logic              tracking
);

  state_t            state;
  logic [CODE_W-1:0] ref_bin;
  logic [CODE_W-1:0] bin_now;
  logic [CODE_W-1:0] diff;

  gray2bin u_dec (
    .gray (gray_in),
    .bin  (bin_now)
  );

  // Modulo-8 distance from the last accepted position
  assign diff = bin_now - ref_bin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      ref_bin  <= '0;
      bin_out  <= '0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      position <= '0;
      rev      <= '0;
      err      <= 1'b0;
      tracking <= 1'b0;
    end else begin
      bin_out <= bin_now;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      case (state)
        S_INIT: begin
          ref_bin  <= bin_now;
          state    <= S_TRACK;
          tracking <= 1'b1;
        end
        S_TRACK: begin
          ref_bin <= bin_now;
          case (diff)
            3'd0: ;
            3'd1: begin
              step_up  <= 1'b1;
              position <= position + POS_W'(1);
              if (ref_bin == 3'd7) rev <= rev + REV_W'(1);
            end
            3'd7: begin
              step_dn  <= 1'b1;
              position <= position - POS_W'(1);
              if (ref_bin == 3'd0) rev <= rev - REV_W'(1);
            end
            default: begin
              // Jump of 2..6 positions: freeze counts until err_clr
              err      <= 1'b1;
              state    <= S_FAULT;
              tracking <= 1'b0;
            end
          endcase
        end
        S_FAULT: begin
          if (err_clr) begin
            err      <= 1'b0;
            ref_bin  <= bin_now;
            state    <= S_TRACK;
            tracking <= 1'b1;
          end
        end
        default: begin
          state    <= S_INIT;
          tracking <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_tracker.sv
// Self-checking bench: directed vector table, wrap/reset sequences and
// randomized stimulus compared against a position-level reference model.
module tb_gray_step_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] gray_in;
  logic       err_clr;
  logic [2:0] bin_out;
  logic       step_up, step_dn;
  logic [7:0] position;
  logic [3:0] rev;
  logic       err, tracking;

  int checks = 0;
  int errors = 0;

  gray_step_tracker #(.POS_W(8), .REV_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .gray_in  (gray_in),
    .err_clr  (err_clr),
    .bin_out  (bin_out),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .position (position),
    .rev      (rev),
    .err      (err),
    .tracking (tracking)
  );

  always #5 clk = ~clk;

  // Gray code of position i
  logic [2:0] gseq [8];
  initial gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  typedef struct {
    logic [2:0] g;
    logic       clr;
    logic [2:0] e_bin;
    logic       e_up;
    logic       e_dn;
    logic [7:0] e_pos;
    logic [3:0] e_rev;
    logic       e_err;
    logic       e_trk;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_bin, input logic e_up,
                           input logic e_dn, input logic [7:0] e_pos, input logic [3:0] e_rev,
                           input logic e_err, input logic e_trk);
    chk({tag, ".bin_out"},  32'(bin_out),  32'(e_bin));
    chk({tag, ".step_up"},  32'(step_up),  32'(e_up));
    chk({tag, ".step_dn"},  32'(step_dn),  32'(e_dn));
    chk({tag, ".position"}, 32'(position), 32'(e_pos));
    chk({tag, ".rev"},      32'(rev),      32'(e_rev));
    chk({tag, ".err"},      32'(err),      32'(e_err));
    chk({tag, ".tracking"}, 32'(tracking), 32'(e_trk));
  endtask

  // Reference model: position index on the ring plus integer counters
  int m_mode;  // 0 = waiting for first sample, 1 = tracking, 2 = faulted
  int m_ref, m_pos, m_rev, m_bin;
  bit m_up, m_dn, m_err, m_trk;

  function automatic int decode(input logic [2:0] g);
    for (int i = 0; i < 8; i++) if (gseq[i] == g) return i;
    return -1;
  endfunction

  function automatic void mdl_reset();
    m_mode = 0; m_ref = 0; m_pos = 0; m_rev = 0; m_bin = 0;
    m_up = 0; m_dn = 0; m_err = 0; m_trk = 0;
  endfunction

  function automatic void mdl_edge(input logic [2:0] g, input logic clr);
    int b, d;
    b = decode(g);
    m_bin = b; m_up = 0; m_dn = 0;
    if (m_mode == 0) begin
      m_ref = b; m_mode = 1; m_trk = 1;
    end else if (m_mode == 1) begin
      d = (b - m_ref + 8) % 8;
      if (d == 1) begin
        m_up = 1; m_pos++;
        if (b == 0) m_rev++;
      end else if (d == 7) begin
        m_dn = 1; m_pos--;
        if (b == 7) m_rev--;
      end else if (d != 0) begin
        m_err = 1; m_mode = 2; m_trk = 0;
      end
      m_ref = b;
    end else if (clr) begin
      m_err = 0; m_ref = b; m_mode = 1; m_trk = 1;
    end
  endfunction

  task automatic check_model(input string tag);
    check_all(tag, 3'(m_bin), m_up, m_dn, 8'(m_pos), 4'(m_rev), m_err, m_trk);
  endtask

  task automatic add(input logic [2:0] g, input logic clr, input logic [2:0] b,
                     input logic u, input logic d, input logic [7:0] p, input logic [3:0] r,
                     input logic e, input logic t);
    vec_t v;
    v.g = g; v.clr = clr; v.e_bin = b; v.e_up = u; v.e_dn = d;
    v.e_pos = p; v.e_rev = r; v.e_err = e; v.e_trk = t;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int idx;

  initial begin
    reset = 1'b1; gray_in = 3'b000; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset", 3'd0, 0, 0, 8'h00, 4'h0, 0, 0);

    // Directed table: hold, down across zero, up across zero, fault/recover
    for (int i = 0; i < 5; i++) add(3'b000, 0, 0, 0, 0, 8'h00, 4'h0, 0, 1);
    add(3'b100, 0, 7, 0, 1, 8'hFF, 4'hF, 0, 1);
    add(3'b101, 0, 6, 0, 1, 8'hFE, 4'hF, 0, 1);
    add(3'b111, 0, 5, 0, 1, 8'hFD, 4'hF, 0, 1);
    add(3'b101, 0, 6, 1, 0, 8'hFE, 4'hF, 0, 1);
    add(3'b100, 0, 7, 1, 0, 8'hFF, 4'hF, 0, 1);
    add(3'b000, 0, 0, 1, 0, 8'h00, 4'h0, 0, 1);
    add(3'b001, 0, 1, 1, 0, 8'h01, 4'h0, 0, 1);
    add(3'b011, 0, 2, 1, 0, 8'h02, 4'h0, 0, 1);
    add(3'b010, 0, 3, 1, 0, 8'h03, 4'h0, 0, 1);
    add(3'b110, 0, 4, 1, 0, 8'h04, 4'h0, 0, 1);
    add(3'b111, 0, 5, 1, 0, 8'h05, 4'h0, 0, 1);
    add(3'b101, 0, 6, 1, 0, 8'h06, 4'h0, 0, 1);
    add(3'b100, 0, 7, 1, 0, 8'h07, 4'h0, 0, 1);
    add(3'b000, 0, 0, 1, 0, 8'h08, 4'h1, 0, 1);
    add(3'b001, 0, 1, 1, 0, 8'h09, 4'h1, 0, 1);
    add(3'b110, 0, 4, 0, 0, 8'h09, 4'h1, 1, 0);
    add(3'b111, 0, 5, 0, 0, 8'h09, 4'h1, 1, 0);
    add(3'b111, 1, 5, 0, 0, 8'h09, 4'h1, 0, 1);
    add(3'b101, 0, 6, 1, 0, 8'h0A, 4'h1, 0, 1);
    add(3'b000, 1, 0, 0, 0, 8'h0A, 4'h1, 1, 0);
    add(3'b000, 0, 0, 0, 0, 8'h0A, 4'h1, 1, 0);
    add(3'b000, 1, 0, 0, 0, 8'h0A, 4'h1, 0, 1);
    add(3'b001, 1, 1, 1, 0, 8'h0B, 4'h1, 0, 1);
    add(3'b001, 0, 1, 0, 0, 8'h0B, 4'h1, 0, 1);

    foreach (vecs[i]) begin
      gray_in = vecs[i].g; err_clr = vecs[i].clr;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_bin, vecs[i].e_up, vecs[i].e_dn,
                vecs[i].e_pos, vecs[i].e_rev, vecs[i].e_err, vecs[i].e_trk);
    end
    err_clr = 1'b0;

    // 128 up-steps from zero: position wraps to -128, rev wraps to 0
    gray_in = 3'b000;
    do_reset();
    @(posedge clk); #1;
    for (int s = 1; s <= 128; s++) begin
      gray_in = gseq[s % 8];
      @(posedge clk); #1;
      if (s == 127) chk("wrap.pos127", 32'(position), 32'h7F);
    end
    chk("wrap.position", 32'(position), 32'h80);
    chk("wrap.rev", 32'(rev), 32'h0);
    chk("wrap.step_up", 32'(step_up), 32'h1);

    // Asynchronous reset at position 5, then INIT on a non-zero code
    gray_in = 3'b000;
    do_reset();
    @(posedge clk); #1;
    for (int s = 1; s <= 5; s++) begin
      gray_in = gseq[s];
      @(posedge clk); #1;
    end
    chk("midrst.pre_pos", 32'(position), 32'h5);
    #2 reset = 1'b1;
    #1;
    check_all("midrst.async", 3'd0, 0, 0, 8'h00, 4'h0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    gray_in = 3'b011;
    @(posedge clk); #1;
    check_all("midrst.init", 3'd2, 0, 0, 8'h00, 4'h0, 0, 1);
    gray_in = 3'b010;
    @(posedge clk); #1;
    check_all("midrst.step", 3'd3, 1, 0, 8'h01, 4'h0, 0, 1);

    // Randomized walk, mostly legal steps, against the reference model
    gray_in = 3'b000; err_clr = 1'b0;
    do_reset();
    mdl_reset();
    idx = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        reset = 1'b1;
        #1;
        mdl_reset();
        check_model($sformatf("rnd%0d.rst", c));
        @(posedge clk); #1;
        reset = 1'b0;
        continue;
      end
      if (r < 88) idx = (idx + int'($urandom_range(0, 2)) + 7) % 8;
      else        idx = int'($urandom_range(0, 7));
      gray_in = gseq[idx];
      err_clr = ($urandom_range(0, 7) == 0);
      mdl_edge(gray_in, err_clr);
      @(posedge clk); #1;
      check_model($sformatf("rnd%0d", c));
      chk($sformatf("rnd%0d.excl", c), 32'(step_up & step_dn), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
